// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
//   Avalon-MM slave holding a 32-bit hex value. It scans the value onto a shared
//   active-low 7-segment bus, and each digit has a one-hot active-low select.
//   Every digit slot is an all-off BLANK phase followed by a DRIVE phase. The
//   displayed value is a shadow copy, and the shadow is reloaded only at frame
//   boundaries so that one frame never mixes old and new digits.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   address[1:0]      : 0 VALUE, 1 CTRL, 2 DIVIDER, 3 STATUS (read-only)
//   chipselect        : slave select
//   write_n           : active-low write strobe
//   writedata[31:0]   : write data
//   readdata[31:0]    : combinational read data, zero wait states
//   seg_n[6:0]        : segments {g,f,e,d,c,b,a}, active-low, registered
//   digit_sel_n[N-1:0]: digit enables, one-hot active-low, registered
//
// Build option
//   HEX_SCAN_BLINK_EN : adds CTRL bit2 (blink_en) and CTRL[23:16] (blink mask).
//                       Blinked digits show all segments off while blink_phase
//                       is set. blink_phase toggles every 32 frames.

module hex_scan_ctrl #(
    parameter int          NUM_DIGITS   = 8,
    parameter int          BLANK_CYCLES = 4,
    parameter logic [31:0] DIV_RESET    = 32'd50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] digit_sel_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Masks are stored as 8 bits, and bits at or above NUM_DIGITS are held at zero.
    localparam logic [7:0]            MASK_ALL   = 8'((9'd1 << NUM_DIGITS) - 9'd1);
    localparam logic [31:0]           BLANK_LOAD = 32'(BLANK_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

    function automatic logic [6:0] decode7(input logic [3:0] nib);
        case (nib)
            4'h0: decode7 = 7'h40;  4'h1: decode7 = 7'h79;
            4'h2: decode7 = 7'h24;  4'h3: decode7 = 7'h30;
            4'h4: decode7 = 7'h19;  4'h5: decode7 = 7'h12;
            4'h6: decode7 = 7'h02;  4'h7: decode7 = 7'h78;
            4'h8: decode7 = 7'h00;  4'h9: decode7 = 7'h10;
            4'hA: decode7 = 7'h08;  4'hB: decode7 = 7'h03;
            4'hC: decode7 = 7'h46;  4'hD: decode7 = 7'h21;
            4'hE: decode7 = 7'h06;  default: decode7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [2:0] i);
        case (i)
            3'd0: nibble_at = v[3:0];    3'd1: nibble_at = v[7:4];
            3'd2: nibble_at = v[11:8];   3'd3: nibble_at = v[15:12];
            3'd4: nibble_at = v[19:16];  3'd5: nibble_at = v[23:20];
            3'd6: nibble_at = v[27:24];  default: nibble_at = v[31:28];
        endcase
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Returns {found, index} for the lowest set bit strictly above cur.
    function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
        next_bit = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) next_bit = {1'b1, 3'(i)};
        end
    endfunction

    logic                  we;
    logic [31:0]           value_q, value_d;
    logic [31:0]           shadow_q, shadow_d;
    logic                  enable_q, enable_d;
    logic [7:0]            mask_q, mask_d;
    logic [31:0]           divider_q, divider_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [2:0]            idx_q, idx_d;
    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic                  drive_now;
    logic                  frame_end;
    logic [3:0]            nxt;
`ifdef HEX_SCAN_BLINK_EN
    logic                  blink_en_q, blink_en_d;
    logic [7:0]            blink_mask_q, blink_mask_d;
    logic [4:0]            blink_div_q, blink_div_d;
    logic                  blink_phase_q, blink_phase_d;
`endif

    assign we = chipselect && !write_n;

    // Bus register writes. STATUS (address 3) is read-only.
    always_comb begin
        value_d   = value_q;
        enable_d  = enable_q;
        mask_d    = mask_q;
        divider_d = divider_q;
`ifdef HEX_SCAN_BLINK_EN
        blink_en_d   = blink_en_q;
        blink_mask_d = blink_mask_q;
`endif
        if (we) begin
            case (address)
                2'd0: value_d = writedata;
                2'd1: begin
                    enable_d = writedata[0];
                    mask_d   = writedata[15:8] & MASK_ALL;
`ifdef HEX_SCAN_BLINK_EN
                    blink_en_d   = writedata[2];
                    blink_mask_d = writedata[23:16] & MASK_ALL;
`endif
                end
                2'd2: divider_d = writedata;
                default: ;
            endcase
        end
    end

    // Scan FSM. The outputs are computed from the next state, so the registered
    // outputs are active in exactly the DRIVE cycles.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        frame_cnt_d = frame_cnt_q;
        seg_n_d     = 7'h7F;
        sel_n_d     = '1;
        drive_now   = 1'b0;
        frame_end   = 1'b0;
        nxt         = next_bit(mask_q, idx_q);
`ifdef HEX_SCAN_BLINK_EN
        blink_div_d   = blink_div_q;
        blink_phase_d = blink_phase_q;
`endif
        if (!enable_q || (mask_q == 8'd0)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    shadow_d = value_q;
                    idx_d    = lowest_bit(mask_q);
                    cnt_d    = BLANK_LOAD;
                    state_d  = ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == 32'd0) begin
                        // A DIVIDER value of 0 gives the same one-cycle drive as 1.
                        cnt_d     = (divider_q == 32'd0) ? 32'd0 : divider_q - 32'd1;
                        state_d   = ST_DRIVE;
                        drive_now = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == 32'd0) begin
                        // The mask is re-read here, so mask edits apply at the next advance.
                        if (nxt[3]) begin
                            idx_d = nxt[2:0];
                        end else begin
                            idx_d       = lowest_bit(mask_q);
                            shadow_d    = value_q;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            frame_end   = 1'b1;
                        end
                        cnt_d   = BLANK_LOAD;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d     = cnt_q - 32'd1;
                        drive_now = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef HEX_SCAN_BLINK_EN
        if (frame_end) begin
            blink_div_d = blink_div_q + 5'd1;
            if (blink_div_q == 5'd31) blink_phase_d = !blink_phase_q;
        end
`endif
        if (drive_now) begin
            seg_n_d = decode7(nibble_at(shadow_q, idx_q));
            sel_n_d = ~(SEL_ONE << idx_q);
`ifdef HEX_SCAN_BLINK_EN
            if (blink_en_q && blink_phase_q && blink_mask_q[idx_q]) seg_n_d = 7'h7F;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q     <= 32'd0;
            shadow_q    <= 32'd0;
            enable_q    <= 1'b0;
            mask_q      <= MASK_ALL;
            divider_q   <= DIV_RESET;
            frame_cnt_q <= 16'd0;
            idx_q       <= 3'd0;
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            seg_n_q     <= 7'h7F;
            sel_n_q     <= '1;
`ifdef HEX_SCAN_BLINK_EN
            blink_en_q    <= 1'b0;
            blink_mask_q  <= 8'd0;
            blink_div_q   <= 5'd0;
            blink_phase_q <= 1'b0;
`endif
        end else begin
            value_q     <= value_d;
            shadow_q    <= shadow_d;
            enable_q    <= enable_d;
            mask_q      <= mask_d;
            divider_q   <= divider_d;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seg_n_q     <= seg_n_d;
            sel_n_q     <= sel_n_d;
`ifdef HEX_SCAN_BLINK_EN
            blink_en_q    <= blink_en_d;
            blink_mask_q  <= blink_mask_d;
            blink_div_q   <= blink_div_d;
            blink_phase_q <= blink_phase_d;
`endif
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = value_q;
`ifdef HEX_SCAN_BLINK_EN
            2'd1: readdata = {8'd0, blink_mask_q, mask_q, 5'd0, blink_en_q, 1'b0, enable_q};
`else
            2'd1: readdata = {16'd0, mask_q, 7'd0, enable_q};
`endif
            2'd2: readdata = divider_q;
            default: readdata = {frame_cnt_q, 11'd0, state_q, idx_q};
        endcase
    end

    assign seg_n       = seg_n_q;
    assign digit_sel_n = sel_n_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  seg_n;
    logic [7:0]  digit_sel_n;

    int tests = 0;
    int fails = 0;
    logic [7:0] low_seen;

    hex_scan_ctrl #(.NUM_DIGITS(8), .BLANK_CYCLES(4), .DIV_RESET(32'd50000)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .seg_n(seg_n), .digit_sel_n(digit_sel_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
        address = 2'd3;
    endtask

    task automatic check_out(input string tag, input logic [6:0] seg_exp, input logic [7:0] sel_exp);
        check({tag, "_seg"}, {25'd0, seg_n}, {25'd0, seg_exp});
        check({tag, "_sel"}, {24'd0, digit_sel_n}, {24'd0, sel_exp});
    endtask

`ifdef HEX_SCAN_BLINK_EN
    task automatic wait_frame(input string tag, input logic [15:0] target);
        int n;
        n = 0;
        address = 2'd3;
        #1;
        while ((n < 2000) && (readdata[31:16] != target)) begin
            tick(1);
            n++;
        end
        check(tag, {16'd0, readdata[31:16]}, {16'd0, target});
    endtask

    task automatic wait_sel(input string tag, input logic [7:0] target);
        int n;
        n = 0;
        while ((n < 50) && (digit_sel_n != target)) begin
            tick(1);
            n++;
        end
        check(tag, {24'd0, digit_sel_n}, {24'd0, target});
    endtask
`endif

    initial begin
        reset = 1'b1; address = 2'd3; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        tick(3);
        reset = 1'b0;

        // Reset state
        check_out("rst", 7'h7F, 8'hFF);
        check_reg("rst_value", 2'd0, 32'h0);
        check_reg("rst_ctrl", 2'd1, 32'h0000FF00);
        check_reg("rst_div", 2'd2, 32'd50000);
        check_reg("rst_status", 2'd3, 32'h0);

        // Full 8-digit scan, DIVIDER=3 (E0 = edge of CTRL write)
        bus_write(2'd0, 32'h89ABCDEF);
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'hFFFFFFFF);
        check_reg("status_ro", 2'd3, 32'h0);
        bus_write(2'd1, 32'h0000FF01);
        check_reg("idle_cycle", 2'd3, 32'h0);
        tick(1);
        check_reg("blank0_status", 2'd3, 32'h00000008);
        check_out("blank0", 7'h7F, 8'hFF);
        tick(3);
        check_out("blank0_last", 7'h7F, 8'hFF);
        tick(1);
        check_out("drive0", 7'h0E, 8'hFE);
        check_reg("drive0_status", 2'd3, 32'h00000010);
        tick(2);
        check_out("drive0_last", 7'h0E, 8'hFE);
        tick(1);
        check_out("blank1", 7'h7F, 8'hFF);
        check_reg("blank1_status", 2'd3, 32'h00000009);
        tick(4);
        check_out("drive1", 7'h06, 8'hFD);
        tick(42);
        check_out("drive7", 7'h00, 8'h7F);
        check_reg("drive7_status", 2'd3, 32'h00000017);
        tick(3);
        check_reg("frame1", 2'd3, 32'h00010008);

        // VALUE written mid-frame keeps the old nibbles until the frame ends
        tick(4);
        check_out("f2_drive0", 7'h0E, 8'hFE);
        bus_write(2'd0, 32'h11111111);
        tick(6);
        check_out("f2_drive1_old", 7'h06, 8'hFD);
        tick(49);
        check_out("f3_drive0_new", 7'h79, 8'hFE);
        check_reg("f3_status", 2'd3, 32'h00020010);

        // VALUE written on the frame-end edge is deferred one frame
        tick(51);
        bus_write(2'd0, 32'h22222222);
        check_reg("f4_status", 2'd3, 32'h00030008);
        tick(4);
        check_out("f4_deferred", 7'h79, 8'hFE);
        tick(56);
        check_out("f5_drive0", 7'h24, 8'hFE);
        check_reg("f5_status", 2'd3, 32'h00040010);

        // Mask 0x05 written mid-frame: only digits 0 and 2 are scanned
        bus_write(2'd1, 32'h00FF0507);
`ifdef HEX_SCAN_BLINK_EN
        check_reg("ctrl_rb", 2'd1, 32'h00FF0505);
`else
        check_reg("ctrl_rb", 2'd1, 32'h00000501);
`endif
        tick(2);
        check_reg("mask_idx2", 2'd3, 32'h0004000A);
        tick(4);
        check_out("mask_drive2", 7'h24, 8'hFB);
        tick(3);
        check_reg("mask_wrap", 2'd3, 32'h00050008);
        tick(4);
        check_out("mask_drive0", 7'h24, 8'hFE);
        low_seen = 8'h00;
        for (int i = 0; i < 28; i++) begin
            tick(1);
            low_seen = low_seen | ~digit_sel_n;
        end
        check("mask_low_seen", {24'd0, low_seen}, 32'h05);

        // Clear enable during a DRIVE of digit 2, then re-enable
        tick(7);
        check_out("pre_dis_drive2", 7'h24, 8'hFB);
        bus_write(2'd1, 32'h00000500);
        tick(1);
        check_out("disabled", 7'h7F, 8'hFF);
        check_reg("disabled_status", 2'd3, 32'h00070002);
        bus_write(2'd1, 32'h00000501);
        tick(1);
        check_reg("reen_status", 2'd3, 32'h00070008);
        tick(4);
        check_out("reen_drive0", 7'h24, 8'hFE);

        // DIVIDER=0 written mid-DRIVE applies from the next DRIVE
        bus_write(2'd2, 32'd0);
        tick(1);
        check_out("div_old_drive", 7'h24, 8'hFE);
        tick(5);
        check_out("div0_drive2", 7'h24, 8'hFB);
        tick(1);
        check_out("div0_after", 7'h7F, 8'hFF);
        check_reg("div0_status", 2'd3, 32'h00080008);
        tick(4);
        check_out("div0_drive0", 7'h24, 8'hFE);

        // Reset during DRIVE with a simultaneous bus write
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'hFFFFFFFF;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
        check_out("mid_rst", 7'h7F, 8'hFF);
        check_reg("mid_rst_value", 2'd0, 32'h0);
        check_reg("mid_rst_ctrl", 2'd1, 32'h0000FF00);
        check_reg("mid_rst_div", 2'd2, 32'd50000);
        check_reg("mid_rst_status", 2'd3, 32'h0);
        reset = 1'b0;

`ifdef HEX_SCAN_BLINK_EN
        // Blink: digit0 blanked during frames 32..63, digit1 unaffected
        bus_write(2'd0, 32'h00000021);
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'h00010305);
        wait_frame("blink_f32", 16'd32);
        wait_sel("blink_sel0", 8'hFE);
        check("blink_seg0_off", {25'd0, seg_n}, 32'h7F);
        wait_sel("blink_sel1", 8'hFD);
        check("blink_seg1_on", {25'd0, seg_n}, 32'h24);
        wait_frame("blink_f64", 16'd64);
        wait_sel("blink_sel0_back", 8'hFE);
        check("blink_seg0_back", {25'd0, seg_n}, 32'h79);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
